memory_arbiter: RTL and testbench

//  Shares the single line-granular main memory between instruction cache (read-only) and

---
 rtl/memory_arbiter.sv | 178 +++++++++++++++++
 tb/tb_memory_arbiter.sv | 300 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/memory_arbiter.sv
// memory_arbiter
//   Shares one line-granular main memory between the instruction cache (reads only)
//   and the data cache (reads and writes). Only one access is in flight at a time.
//   Round-robin arbitration applies when both caches request at once. A fixed latency
//   models slow DRAM.
//   Each access walks IDLE -> ACCESS -> WAIT (MEM_LATENCY cycles) -> RESPOND -> IDLE.
//
// Ports
//   clk, rst              clock (posedge), asynchronous active-high reset
//   ic_req/ic_addr        icache line-read request, held until ic_ack
//   ic_data/ic_ack        returned line, valid during the one-cycle ic_ack pulse
//   dc_req/dc_we/dc_addr  dcache request (dc_we=1 line write), held until dc_ack
//   dc_wdata              dcache write line
//   dc_rdata/dc_ack       returned line, valid during the one-cycle dc_ack pulse
//   mem_we/mem_re         memory write/read enables, high only in the ACCESS cycle
//   mem_addr/mem_wdata    line-aligned address and write line toward memory
//   mem_rdata             memory read data, registered inside the memory
module memory_arbiter #(
  parameter int ADDRESS_SIZE    = 12,
  parameter int CACHE_LINE_SIZE = 128,
  parameter int MEM_LATENCY     = 4
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       ic_req,
  input  logic [ADDRESS_SIZE-1:0]    ic_addr,
  output logic [CACHE_LINE_SIZE-1:0] ic_data,
  output logic                       ic_ack,
  input  logic                       dc_req,
  input  logic                       dc_we,
  input  logic [ADDRESS_SIZE-1:0]    dc_addr,
  input  logic [CACHE_LINE_SIZE-1:0] dc_wdata,
  output logic [CACHE_LINE_SIZE-1:0] dc_rdata,
  output logic                       dc_ack,
  output logic                       mem_we,
  output logic                       mem_re,
  output logic [ADDRESS_SIZE-1:0]    mem_addr,
  output logic [CACHE_LINE_SIZE-1:0] mem_wdata,
  input  logic [CACHE_LINE_SIZE-1:0] mem_rdata
);

  localparam int         OFFSET   = $clog2(CACHE_LINE_SIZE / 8);
  localparam int         LA_W     = ADDRESS_SIZE - OFFSET;
  localparam logic       ID_IC    = 1'b0;
  localparam logic       ID_DC    = 1'b1;
  localparam logic [3:0] CNT_LOAD = 4'(MEM_LATENCY - 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_ACCESS,
    S_WAIT,
    S_RESPOND
  } state_t;

  state_t                     r_state;
  state_t                     w_state_next;
  logic                       r_id;
  logic                       r_last_grant;
  logic                       r_we;
  logic [LA_W-1:0]            r_line_addr;
  logic [CACHE_LINE_SIZE-1:0] r_wdata;
  logic [CACHE_LINE_SIZE-1:0] r_line;
  logic [3:0]                 r_cnt;
  logic                       w_grant;
  logic                       w_grant_id;
  logic                       w_unused_offset_bits;

  // Byte-offset bits never reach memory; only whole lines are transferred.
  assign w_unused_offset_bits = ^{ic_addr[OFFSET-1:0], dc_addr[OFFSET-1:0]};

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  always_comb begin
    w_state_next = r_state;
    w_grant      = 1'b0;
    w_grant_id   = ID_DC;
    mem_we       = 1'b0;
    mem_re       = 1'b0;
    mem_addr     = '0;
    mem_wdata    = '0;
    ic_ack       = 1'b0;
    ic_data      = '0;
    dc_ack       = 1'b0;
    dc_rdata     = '0;
    case (r_state)
      S_IDLE: begin
        // On contention, the side that did not win last time gets the grant.
        if (ic_req && dc_req) begin
          w_grant    = 1'b1;
          w_grant_id = ~r_last_grant;
        end else if (ic_req) begin
          w_grant    = 1'b1;
          w_grant_id = ID_IC;
        end else if (dc_req) begin
          w_grant    = 1'b1;
          w_grant_id = ID_DC;
        end
        if (w_grant) begin
          w_state_next = S_ACCESS;
        end
      end
      S_ACCESS: begin
        mem_we       = r_we;
        mem_re       = ~r_we;
        mem_addr     = {r_line_addr, {OFFSET{1'b0}}};
        mem_wdata    = r_wdata;
        w_state_next = S_WAIT;
      end
      S_WAIT: begin
        if (r_cnt == 4'd0) begin
          w_state_next = S_RESPOND;
        end
      end
      S_RESPOND: begin
        if (r_id == ID_IC) begin
          ic_ack  = 1'b1;
          ic_data = r_line;
        end else begin
          dc_ack   = 1'b1;
          dc_rdata = r_we ? '0 : r_line;
        end
        w_state_next = S_IDLE;
      end
      default: w_state_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_id         <= ID_IC;
      r_last_grant <= ID_DC;
      r_we         <= 1'b0;
      r_line_addr  <= '0;
      r_wdata      <= '0;
      r_line       <= '0;
      r_cnt        <= 4'd0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_grant) begin
            r_id         <= w_grant_id;
            r_last_grant <= w_grant_id;
            if (w_grant_id == ID_DC) begin
              r_we        <= dc_we;
              r_line_addr <= dc_addr[ADDRESS_SIZE-1:OFFSET];
              r_wdata     <= dc_wdata;
            end else begin
              r_we        <= 1'b0;
              r_line_addr <= ic_addr[ADDRESS_SIZE-1:OFFSET];
              r_wdata     <= '0;
            end
          end
        end
        S_ACCESS: begin
          r_cnt <= CNT_LOAD;
        end
        S_WAIT: begin
          // The memory registers its output, so read data is valid in the first WAIT
          // cycle. That cycle is the only one where the counter still holds its load value.
          if ((r_cnt == CNT_LOAD) && !r_we) begin
            r_line <= mem_rdata;
          end
          if (r_cnt != 4'd0) begin
            r_cnt <= r_cnt - 4'd1;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_memory_arbiter.sv
module tb_memory_arbiter;
  localparam int   AW  = 12;
  localparam int   LW  = 128;
  localparam int   LAT = 4;
  localparam logic IC  = 1'b0;
  localparam logic DC  = 1'b1;

  typedef struct {
    logic          we;
    logic [AW-1:0] addr;
    logic [LW-1:0] wdata;
  } req_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic          ic_req = 0, dc_req = 0, dc_we = 0;
  logic [AW-1:0] ic_addr = '0, dc_addr = '0;
  logic [LW-1:0] dc_wdata = '0;
  logic [LW-1:0] ic_data, dc_rdata, mem_wdata, mem_rdata;
  logic          ic_ack, dc_ack, mem_we, mem_re;
  logic [AW-1:0] mem_addr;

  logic          l1_ic_req = 0, l1_dc_req = 0, l1_dc_we = 0;
  logic [AW-1:0] l1_ic_addr = '0, l1_dc_addr = '0;
  logic [LW-1:0] l1_dc_wdata = '0;
  logic [LW-1:0] l1_ic_data, l1_dc_rdata, l1_mem_wdata, l1_mem_rdata;
  logic          l1_ic_ack, l1_dc_ack, l1_mem_we, l1_mem_re;
  logic [AW-1:0] l1_mem_addr;

  memory_arbiter #(.ADDRESS_SIZE(AW), .CACHE_LINE_SIZE(LW), .MEM_LATENCY(LAT)) dut (
    .clk(clk), .rst(rst),
    .ic_req(ic_req), .ic_addr(ic_addr), .ic_data(ic_data), .ic_ack(ic_ack),
    .dc_req(dc_req), .dc_we(dc_we), .dc_addr(dc_addr), .dc_wdata(dc_wdata),
    .dc_rdata(dc_rdata), .dc_ack(dc_ack),
    .mem_we(mem_we), .mem_re(mem_re), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata)
  );

  memory_arbiter #(.ADDRESS_SIZE(AW), .CACHE_LINE_SIZE(LW), .MEM_LATENCY(1)) dut_l1 (
    .clk(clk), .rst(rst),
    .ic_req(l1_ic_req), .ic_addr(l1_ic_addr), .ic_data(l1_ic_data), .ic_ack(l1_ic_ack),
    .dc_req(l1_dc_req), .dc_we(l1_dc_we), .dc_addr(l1_dc_addr), .dc_wdata(l1_dc_wdata),
    .dc_rdata(l1_dc_rdata), .dc_ack(l1_dc_ack),
    .mem_we(l1_mem_we), .mem_re(l1_mem_re), .mem_addr(l1_mem_addr), .mem_wdata(l1_mem_wdata),
    .mem_rdata(l1_mem_rdata)
  );

  // Byte b of line l holds (16*l + b - 0x40): line 0x04 holds 0x00..0x0F.
  function automatic logic [LW-1:0] init_line(int l);
    logic [LW-1:0] r;
    for (int b = 0; b < 16; b++) r[8*b +: 8] = 8'(16 * l + b - 64);
    return r;
  endfunction

  // Memory with registered read port, shared by both arbiter instances.
  logic [LW-1:0] mem [256];
  initial begin
    for (int l = 0; l < 256; l++) mem[l] = init_line(l);
    mem_rdata    = '0;
    l1_mem_rdata = '0;
    forever begin
      @(posedge clk);
      if (mem_we) mem[mem_addr[AW-1:4]] <= mem_wdata;
      if (mem_re) mem_rdata <= mem[mem_addr[AW-1:4]];
      if (l1_mem_re) l1_mem_rdata <= mem[l1_mem_addr[AW-1:4]];
    end
  end

  int n_checks = 0, n_errors = 0;

  task automatic chk1(string tag, logic obs, logic exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s observed=%0b expected=%0b", tag, obs, exp);
    end
  endtask

  task automatic chkw(string tag, logic [LW-1:0] obs, logic [LW-1:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic chki(string tag, int obs, int exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // Requester agents and transaction-level reference model
  req_t          ic_q[$], dc_q[$];
  logic          ic_act = 0, dc_act = 0;
  logic [LW-1:0] ref_mem [256];
  int            cyc = 0, m_free = 0;
  logic          m_last = DC;
  logic          x_valid = 0, x_id = IC, x_we = 0;
  int            x_g = 0;
  logic [AW-1:0] x_addr = '0;
  logic [LW-1:0] x_wdata = '0, x_line = '0;
  logic [LW-1:0] last_ic_data = '0, last_dc_data = '0;
  int            ack_cyc_q[$];
  logic          ack_id_q[$];

  task automatic step();
    logic acc, rsp, w;
    req_t r;
    @(negedge clk);
    cyc++;
    acc = x_valid && (cyc == x_g + 1);
    rsp = x_valid && (cyc == x_g + LAT + 2);
    chk1("mem_re", mem_re, acc && !x_we);
    chk1("mem_we", mem_we, acc && x_we);
    if (acc) begin
      chkw("mem_addr", LW'(mem_addr), LW'({x_addr[AW-1:4], 4'h0}));
      chkw("mem_wdata", mem_wdata, x_wdata);
    end
    chk1("ic_ack", ic_ack, rsp && (x_id == IC));
    chk1("dc_ack", dc_ack, rsp && (x_id == DC));
    if (rsp) begin
      ack_cyc_q.push_back(cyc);
      ack_id_q.push_back(x_id);
      if (x_id == IC) begin
        chkw("ic_data", ic_data, x_line);
        last_ic_data = ic_data;
        ic_act = 0;
        ic_req = 0;
      end else begin
        if (!x_we) chkw("dc_rdata", dc_rdata, x_line);
        last_dc_data = dc_rdata;
        dc_act = 0;
        dc_req = 0;
      end
      x_valid = 0;
    end
    if (rst) rst = 0;
    if (!ic_act && ic_q.size() > 0) begin
      r = ic_q.pop_front();
      ic_req = 1; ic_addr = r.addr; ic_act = 1;
    end
    if (!dc_act && dc_q.size() > 0) begin
      r = dc_q.pop_front();
      dc_req = 1; dc_we = r.we; dc_addr = r.addr; dc_wdata = r.wdata; dc_act = 1;
    end
    if (!x_valid && cyc >= m_free && (ic_req || dc_req)) begin
      w = (ic_req && dc_req) ? ~m_last : (ic_req ? IC : DC);
      m_last  = w;
      x_valid = 1;
      x_g     = cyc;
      x_id    = w;
      if (w == IC) begin
        x_we = 0; x_addr = ic_addr; x_wdata = '0;
      end else begin
        x_we = dc_we; x_addr = dc_addr; x_wdata = dc_wdata;
      end
      x_line = ref_mem[x_addr[AW-1:4]];
      if (x_we) ref_mem[x_addr[AW-1:4]] = x_wdata;
      m_free = cyc + LAT + 3;
    end
  endtask

  task automatic wait_idle(string tag);
    logic done;
    done = 0;
    for (int i = 0; i < 400; i++) begin
      if (ic_q.size() == 0 && dc_q.size() == 0 && !ic_act && !dc_act && !x_valid) begin
        done = 1;
        break;
      end
      step();
    end
    n_checks++;
    assert (done) else begin
      n_errors++;
      $error("FAIL %s_timeout observed=busy expected=idle", tag);
    end
  endtask

  task automatic chk_outputs_zero(string tag);
    chk1({tag, "_mem_re"}, mem_re, 1'b0);
    chk1({tag, "_mem_we"}, mem_we, 1'b0);
    chkw({tag, "_mem_addr"}, LW'(mem_addr), '0);
    chkw({tag, "_mem_wdata"}, mem_wdata, '0);
    chk1({tag, "_ic_ack"}, ic_ack, 1'b0);
    chkw({tag, "_ic_data"}, ic_data, '0);
    chk1({tag, "_dc_ack"}, dc_ack, 1'b0);
    chkw({tag, "_dc_rdata"}, dc_rdata, '0);
  endtask

  initial begin
    int t0;
    logic [LW-1:0] wline, exp1;
    for (int l = 0; l < 256; l++) ref_mem[l] = init_line(l);

    // Reset state
    #12;
    chk_outputs_zero("reset");
    @(negedge clk);
    rst = 0;

    // 1: icache read of line 0x040
    t0 = cyc + 1;
    ack_cyc_q.delete(); ack_id_q.delete();
    ic_q.push_back('{we: 1'b0, addr: 12'h040, wdata: '0});
    wait_idle("t1");
    exp1 = 128'h0F0E0D0C0B0A09080706050403020100;
    chkw("t1_ic_data", last_ic_data, exp1);
    chki("t1_latency", (ack_cyc_q.size() > 0) ? ack_cyc_q[0] - t0 : -1, LAT + 2);

    // 2: dcache write then read back line 0x100
    wline = 128'hDEADBEEF_01234567_89ABCDEF_CAFEF00D;
    dc_q.push_back('{we: 1'b1, addr: 12'h100, wdata: wline});
    dc_q.push_back('{we: 1'b0, addr: 12'h100, wdata: 128'h5A5A});
    wait_idle("t2");
    chkw("t2_readback", last_dc_data, wline);

    // 5 (main build): dcache read at 0x123 goes to line 0x120
    dc_q.push_back('{we: 1'b0, addr: 12'h123, wdata: '0});
    wait_idle("t5a");

    // 3: simultaneous requests right after reset; icache wins first contention
    @(negedge clk);
    rst = 1;
    x_valid = 0; m_last = DC; m_free = cyc + 1;
    step();
    t0 = cyc + 1;
    ack_cyc_q.delete(); ack_id_q.delete();
    ic_q.push_back('{we: 1'b0, addr: 12'h050, wdata: '0});
    dc_q.push_back('{we: 1'b0, addr: 12'h060, wdata: '0});
    wait_idle("t3");
    chki("t3_acks", ack_cyc_q.size(), 2);
    if (ack_cyc_q.size() == 2) begin
      chk1("t3_first_id", ack_id_q[0], IC);
      chki("t3_ic_ack_cycle", ack_cyc_q[0] - t0, LAT + 2);
      chki("t3_dc_ack_cycle", ack_cyc_q[1] - t0, 2 * LAT + 5);
    end

    // 4: both held for four accesses; grants alternate, acks MEM_LATENCY+3 apart
    ack_cyc_q.delete(); ack_id_q.delete();
    for (int i = 0; i < 2; i++) begin
      ic_q.push_back('{we: 1'b0, addr: 12'(16 * i + 12'h070), wdata: '0});
      dc_q.push_back('{we: 1'b1, addr: 12'(16 * i + 12'h090), wdata: {4{$urandom}}});
    end
    wait_idle("t4");
    chki("t4_acks", ack_cyc_q.size(), 4);
    for (int i = 0; i < ack_cyc_q.size(); i++) begin
      chk1("t4_alternate", ack_id_q[i], (i % 2 == 0) ? IC : DC);
      if (i > 0) chki("t4_spacing", ack_cyc_q[i] - ack_cyc_q[i-1], LAT + 3);
    end

    // 6: reset during WAIT of an icache read; held request served afterwards
    ack_cyc_q.delete(); ack_id_q.delete();
    ic_q.push_back('{we: 1'b0, addr: 12'h0A0, wdata: '0});
    for (int i = 0; i < 20 && !(x_valid && cyc == x_g + 3); i++) step();
    chki("t6_in_wait", cyc - x_g, 3);
    rst = 1;
    #1;
    chk_outputs_zero("t6_rst");
    x_valid = 0; m_last = DC; m_free = cyc + 1;
    wait_idle("t6");
    chki("t6_single_ack", ack_cyc_q.size(), 1);
    chkw("t6_ic_data", last_ic_data, ref_mem[8'h0A]);

    // Randomized traffic over a small set of lines
    for (int n = 0; n < 400; n++) begin
      if ($urandom_range(0, 5) == 0 && ic_q.size() < 2)
        ic_q.push_back('{we: 1'b0, addr: {4'h2, 4'($urandom_range(0, 7)), 4'($urandom)}, wdata: '0});
      if ($urandom_range(0, 5) == 0 && dc_q.size() < 2)
        dc_q.push_back('{we: 1'($urandom), addr: {4'h2, 4'($urandom_range(0, 7)), 4'($urandom)},
                         wdata: {$urandom, $urandom, $urandom, $urandom}});
      step();
    end
    wait_idle("rand");

    // 5 (MEM_LATENCY=1 build): read 0x123 -> mem_addr 0x120, ack in cycle 3
    @(negedge clk);
    l1_dc_req = 1; l1_dc_we = 0; l1_dc_addr = 12'h123;
    @(negedge clk);
    chk1("l1_mem_re", l1_mem_re, 1'b1);
    chkw("l1_mem_addr", LW'(l1_mem_addr), LW'(12'h120));
    @(negedge clk);
    chk1("l1_early_ack", l1_dc_ack, 1'b0);
    @(negedge clk);
    chk1("l1_dc_ack", l1_dc_ack, 1'b1);
    chkw("l1_dc_rdata", l1_dc_rdata, ref_mem[8'h12]);
    l1_dc_req = 0;
    @(negedge clk);
    chk1("l1_ack_pulse", l1_dc_ack, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
